tamagotchi_needs_engine: RTL and testbench

- Parametrised successor of the single-pet needs FSM.
- Tracks N_NEEDS independent need levels, each with its own decay and its own feed/hold timing.
- Has three modes: NORMAL, TEST and DEAD.
- Runs off an external tick strobe, not an internal divider, so one engine can serve any board clock.
- Feeds the face/level display logic through a selected-channel index, a mood flag and packed level outputs.

---
 rtl/tamagotchi_needs_engine.sv | 174 +++++++++++++++++
 tb/tb_tamagotchi_needs_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_needs_engine.sv
// Multi-channel pet needs engine: per-channel decay, press-and-hold feeding,
// lowest-index request arbitration, and NORMAL/TEST/DEAD mode handling.
// All state changes are qualified by an external tick strobe.
module tamagotchi_needs_engine #(
  parameter int unsigned                  N_NEEDS     = 4,
  parameter int unsigned                  SEL_W       = 2,
  parameter int unsigned                  LVL_W       = 4,
  parameter int unsigned                  LVL_MIN     = 1,
  parameter int unsigned                  LVL_MAX     = 10,
  parameter int unsigned                  HAPPY_TH    = 5,
  parameter int unsigned                  DECAY_TICKS = 24,
  parameter logic [N_NEEDS*LVL_W-1:0]     INIT_LVL    = 16'h8888,
  parameter logic [8*N_NEEDS-1:0]         HOLD_TICKS  = 32'h06000C00,
  parameter int unsigned                  ENERGY_CH   = 1
) (
  input  logic                       clk,
  input  logic                       btn_reset,
  input  logic                       tick,
  input  logic [N_NEEDS-1:0]         req,
  input  logic                       test_toggle,
  output logic [N_NEEDS*LVL_W-1:0]   levels_out,
  output logic [SEL_W-1:0]           sel,
  output logic                       happy,
  output logic                       asleep,
  output logic                       dead,
  output logic                       test_active,
  output logic [N_NEEDS-1:0]         decay_ev
);

  typedef enum logic [1:0] {
    MODE_NORMAL,
    MODE_TEST,
    MODE_DEAD
  } mode_e;

  localparam logic [LVL_W-1:0] LMIN       = LVL_W'(LVL_MIN);
  localparam logic [LVL_W-1:0] LMAX       = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LHAPPY     = LVL_W'(HAPPY_TH);
  localparam logic [7:0]       DECAY_LAST = 8'(DECAY_TICKS - 1);

  mode_e                mode_q, mode_d;
  logic [LVL_W-1:0]     level_q     [N_NEEDS];
  logic [LVL_W-1:0]     level_d     [N_NEEDS];
  logic [7:0]           decay_cnt_q [N_NEEDS];
  logic [7:0]           decay_cnt_d [N_NEEDS];
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 test_pend_q, test_pend_d;
  logic [N_NEEDS-1:0]   decay_ev_q, decay_ev_d;

  logic                 win_valid;
  logic [SEL_W-1:0]     win_idx;
  logic [7:0]           hold_th;
  logic                 all_min;
  logic                 feed;
  logic [LVL_W-1:0]     sel_level;

  // Arbitration: lowest-index active request wins; also looks up its hold time
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    hold_th   = '0;
    all_min   = 1'b1;
    sel_level = '0;
    for (int unsigned i = 0; i < N_NEEDS; i++) begin
      if (req[i] && !win_valid) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(i);
        hold_th   = HOLD_TICKS[8*i +: 8];
      end
      if (level_q[i] != LMIN) all_min = 1'b0;
      if (sel_q == SEL_W'(i)) sel_level = level_q[i];
    end
  end

  // Next-state: mode change first, then death check, then feed and decay
  always_comb begin
    mode_d      = mode_q;
    level_d     = level_q;
    decay_cnt_d = decay_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    sel_d       = sel_q;
    test_pend_d = test_pend_q | test_toggle;
    decay_ev_d  = '0;
    feed        = 1'b0;
    if (tick) begin
      if (test_pend_q) begin
        // A toggle arriving on the consuming tick stays pending for the next one
        test_pend_d = test_toggle;
        hold_cnt_d  = '0;
        for (int unsigned i = 0; i < N_NEEDS; i++) begin
          decay_cnt_d[i] = '0;
          level_d[i]     = (mode_q == MODE_TEST) ? INIT_LVL[LVL_W*i +: LVL_W] : LMIN;
        end
        mode_d = (mode_q == MODE_TEST) ? MODE_NORMAL : MODE_TEST;
      end else if (mode_q == MODE_DEAD) begin
        mode_d = MODE_DEAD;
      end else if (mode_q == MODE_NORMAL && all_min) begin
        mode_d = MODE_DEAD;
      end else begin
        if (win_valid) begin
          sel_d = win_idx;
          if (win_idx != sel_q) begin
            hold_cnt_d = '0;
          end else if (hold_cnt_q >= hold_th) begin
            feed       = 1'b1;
            hold_cnt_d = '0;
          end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end else begin
          hold_cnt_d = '0;
        end
        for (int unsigned i = 0; i < N_NEEDS; i++) begin
          if (win_valid && win_idx == SEL_W'(i)) begin
            if (feed) begin
              if (mode_q == MODE_TEST)
                level_d[i] = (level_q[i] == LMIN) ? LMAX : LMIN;
              else if (level_q[i] < LMAX)
                level_d[i] = level_q[i] + LVL_W'(1);
            end
          end else if (mode_q == MODE_NORMAL) begin
            if (level_q[i] <= LMIN) begin
              decay_cnt_d[i] = '0;
            end else if (decay_cnt_q[i] >= DECAY_LAST) begin
              decay_cnt_d[i] = '0;
              level_d[i]     = level_q[i] - LVL_W'(1);
              decay_ev_d[i]  = 1'b1;
            end else if (decay_cnt_q[i] != 8'hFF) begin
              decay_cnt_d[i] = decay_cnt_q[i] + 8'd1;
            end
          end
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      mode_q      <= MODE_NORMAL;
      hold_cnt_q  <= '0;
      sel_q       <= '0;
      test_pend_q <= 1'b0;
      decay_ev_q  <= '0;
      for (int unsigned i = 0; i < N_NEEDS; i++) begin
        level_q[i]     <= INIT_LVL[LVL_W*i +: LVL_W];
        decay_cnt_q[i] <= '0;
      end
    end else begin
      mode_q      <= mode_d;
      hold_cnt_q  <= hold_cnt_d;
      sel_q       <= sel_d;
      test_pend_q <= test_pend_d;
      decay_ev_q  <= decay_ev_d;
      level_q     <= level_d;
      decay_cnt_q <= decay_cnt_d;
    end
  end

  // Output packing and status flags
  always_comb begin
    for (int unsigned i = 0; i < N_NEEDS; i++)
      levels_out[LVL_W*i +: LVL_W] = level_q[i];
  end

  assign sel         = sel_q;
  assign happy       = (sel_level >= LHAPPY);
  assign asleep      = (mode_q == MODE_NORMAL) && win_valid && (win_idx == SEL_W'(ENERGY_CH));
  assign dead        = (mode_q == MODE_DEAD);
  assign test_active = (mode_q == MODE_TEST);
  assign decay_ev    = decay_ev_q;

endmodule

// File: tb/tb_tamagotchi_needs_engine.sv
// Directed bench for the needs engine with hand-computed expected values.
module tb_tamagotchi_needs_engine;

  logic        clk = 1'b0;
  logic        btn_reset = 1'b1;
  logic        tick = 1'b0;
  logic [3:0]  req = '0;
  logic        test_toggle = 1'b0;
  logic [15:0] levels_out;
  logic [1:0]  sel;
  logic        happy, asleep, dead, test_active;
  logic [3:0]  decay_ev;

  int total = 0;
  int bad   = 0;

  tamagotchi_needs_engine #(
    .N_NEEDS(4), .SEL_W(2), .LVL_W(4), .LVL_MIN(1), .LVL_MAX(10),
    .HAPPY_TH(5), .DECAY_TICKS(24), .INIT_LVL(16'h8888),
    .HOLD_TICKS(32'h06000C00), .ENERGY_CH(1)
  ) dut (
    .clk(clk), .btn_reset(btn_reset), .tick(tick), .req(req),
    .test_toggle(test_toggle), .levels_out(levels_out), .sel(sel),
    .happy(happy), .asleep(asleep), .dead(dead), .test_active(test_active),
    .decay_ev(decay_ev)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One tick per clk for n clks; returns on the negedge after the last tick edge
  task automatic do_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  task automatic pulse_toggle();
    test_toggle = 1'b1;
    @(negedge clk);
    test_toggle = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    btn_reset = 1'b0;
    chk("rst_levels", 32'(levels_out), 32'h8888);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_dead", 32'(dead), 0);
    chk("rst_test", 32'(test_active), 0);
    chk("rst_ev", 32'(decay_ev), 0);
    chk("rst_happy", 32'(happy), 1);

    // Idle decay: first decrement on tick 24
    do_ticks(23);
    chk("decay23_levels", 32'(levels_out), 32'h8888);
    chk("decay23_ev", 32'(decay_ev), 0);
    do_ticks(1);
    chk("decay24_levels", 32'(levels_out), 32'h7777);
    chk("decay24_ev", 32'(decay_ev), 4'b1111);
    chk("decay24_happy", 32'(happy), 1);
    @(negedge clk);
    chk("decay_ev_oneclk", 32'(decay_ev), 0);
    do_ticks(48);
    chk("decay72_levels", 32'(levels_out), 32'h5555);

    // Hold-feed on ch3 (hold 6): select on tick 1, feeds at 8,15,22,...
    req = 4'b1000;
    do_ticks(1);
    chk("ch3_sel", 32'(sel), 3);
    chk("ch3_t1", 32'(levels_out), 32'h5555);
    do_ticks(6);
    chk("ch3_t7", 32'(levels_out), 32'h5555);
    do_ticks(1);
    chk("ch3_t8", 32'(levels_out), 32'h6555);
    do_ticks(7);
    chk("ch3_t15", 32'(levels_out), 32'h7555);
    do_ticks(7);
    chk("ch3_t22", 32'(levels_out), 32'h8555);
    do_ticks(2);
    chk("ch3_t24", 32'(levels_out), 32'h8444);
    chk("ch3_t24_ev", 32'(decay_ev), 4'b0111);
    do_ticks(19);
    chk("ch3_t43", 32'(levels_out), 32'hA444);
    do_ticks(7);
    chk("ch3_t50_sat", 32'(levels_out), 32'hA333);
    chk("ch3_happy", 32'(happy), 1);
    chk("ch3_asleep", 32'(asleep), 0);

    // Energy channel wins over ch2: asleep, feeds every 13 ticks
    req = 4'b0110;
    #1;
    chk("en_asleep", 32'(asleep), 1);
    do_ticks(1);
    chk("en_sel", 32'(sel), 1);
    do_ticks(13);
    chk("en_t14", 32'(levels_out), 32'hA343);
    chk("en_t14_happy", 32'(happy), 0);
    do_ticks(8);
    chk("en_t22", 32'(levels_out), 32'hA242);
    do_ticks(2);
    chk("en_t24", 32'(levels_out), 32'h9242);
    do_ticks(3);
    chk("en_t27", 32'(levels_out), 32'h9252);
    chk("en_t27_happy", 32'(happy), 1);

    // Starve everything to the floor, then die on the following tick
    req = 4'b0000;
    do_ticks(189);
    chk("floor_levels", 32'(levels_out), 32'h1111);
    chk("floor_ev", 32'(decay_ev), 4'b1000);
    chk("floor_alive", 32'(dead), 0);
    do_ticks(1);
    chk("dead_flag", 32'(dead), 1);
    for (int k = 0; k < 50; k++) begin
      req = (k % 2 == 0) ? 4'b0101 : 4'b0000;
      do_ticks(1);
    end
    req = 4'b0000;
    chk("dead_levels", 32'(levels_out), 32'h1111);
    chk("dead_sel", 32'(sel), 1);
    chk("dead_still", 32'(dead), 1);
    pulse_toggle();
    do_ticks(1);
    chk("dead_to_test", 32'(test_active), 1);
    chk("dead_to_test_dead", 32'(dead), 0);
    chk("dead_to_test_lv", 32'(levels_out), 32'h1111);

    // TEST mode: held req[0] toggles level 0 every tick after selection
    req = 4'b0001;
    do_ticks(1);
    chk("test_sel", 32'(sel), 0);
    chk("test_t1", 32'(levels_out), 32'h1111);
    do_ticks(1);
    chk("test_t2", 32'(levels_out), 32'h111A);
    do_ticks(1);
    chk("test_t3", 32'(levels_out), 32'h1111);
    chk("test_ev", 32'(decay_ev), 0);
    do_ticks(1);
    chk("test_t4", 32'(levels_out), 32'h111A);
    req = 4'b0000;
    pulse_toggle();
    do_ticks(1);
    chk("test_exit_mode", 32'(test_active), 0);
    chk("test_exit_lv", 32'(levels_out), 32'h8888);

    // Reset coinciding with tick and toggle while in TEST
    pulse_toggle();
    do_ticks(1);
    chk("retest", 32'(test_active), 1);
    btn_reset = 1'b1;
    tick = 1'b1;
    test_toggle = 1'b1;
    @(negedge clk);
    btn_reset = 1'b0;
    tick = 1'b0;
    test_toggle = 1'b0;
    chk("rst_mid_mode", 32'(test_active), 0);
    chk("rst_mid_lv", 32'(levels_out), 32'h8888);
    chk("rst_mid_ev", 32'(decay_ev), 0);
    chk("rst_mid_sel", 32'(sel), 0);
    do_ticks(1);
    chk("rst_mid_nopend", 32'(test_active), 0);
    do_ticks(22);
    chk("rst_mid_t23", 32'(levels_out), 32'h8888);
    do_ticks(1);
    chk("rst_mid_t24", 32'(levels_out), 32'h7777);
    chk("rst_mid_t24_ev", 32'(decay_ev), 4'b1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
